spi_avalon_csr: RTL and testbench

//  Avalon-MM slave front-end that sits directly upstream of the SPI packet core.

---
 rtl/spi_avalon_pkg.sv | 34 +++
 rtl/spi_word_fifo.sv | 52 +++++
 rtl/spi_avalon_csr.sv | 176 +++++++++++++++++
 tb/tb_spi_avalon_csr.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_avalon_pkg.sv
// Shared constants for the SPI Avalon CSR front-end: register map, STATUS/CONTROL
// bit positions and the packet sequencer state encoding.
package spi_avalon_pkg;

   localparam logic [1:0] REG_TXDATA  = 2'd0;
   localparam logic [1:0] REG_RXDATA  = 2'd1;
   localparam logic [1:0] REG_STATUS  = 2'd2;
   localparam logic [1:0] REG_CONTROL = 2'd3;

   localparam int ST_BUSY     = 0;
   localparam int ST_TX_FULL  = 1;
   localparam int ST_TX_EMPTY = 2;
   localparam int ST_RX_FULL  = 3;
   localparam int ST_RX_EMPTY = 4;
   localparam int ST_TX_OVF   = 5;
   localparam int ST_RX_OVF   = 6;
   localparam int ST_TIMEOUT  = 7;
   localparam int ST_TX_LVL   = 8;
   localparam int ST_RX_LVL   = 16;

   localparam int CTL_ENABLE  = 0;
   localparam int CTL_IRQ_EN  = 1;
   localparam int CTL_CLR     = 2;

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      LOAD         = 3'd1,
      GO           = 3'd2,
      WAIT_DONE    = 3'd3,
      CAPTURE      = 3'd4,
      WAIT_RELEASE = 3'd5
   } state_t;

endpackage

// File: rtl/spi_word_fifo.sv
// Synchronous 32-bit word FIFO; a push while full is accepted only when a pop
// happens in the same cycle.
module spi_word_fifo #(
   parameter int DEPTH = 8,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk_shift,
   input  logic          reset_n,
   input  logic          i_push,
   input  logic          i_pop,
   input  logic [31:0]   i_wdata,
   output logic [31:0]   o_rdata,
   output logic          o_full,
   output logic          o_empty,
   output logic [AW:0]   o_level
);

   logic [31:0]   r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_level;
   logic          w_do_push;
   logic          w_do_pop;

   assign o_full    = (r_level == (AW+1)'(DEPTH));
   assign o_empty   = (r_level == '0);
   assign o_level   = r_level;
   assign o_rdata   = r_mem[r_rptr];
   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~o_full | w_do_pop);

   always_ff @(posedge clk_shift) begin
      if (w_do_push) r_mem[r_wptr] <= i_wdata;
   end

   always_ff @(posedge clk_shift or negedge reset_n) begin
      if (!reset_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + AW'(1);
         if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_level <= r_level + (AW+1)'(1);
            2'b01:   r_level <= r_level - (AW+1)'(1);
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/spi_avalon_csr.sv
// Avalon-MM CSR front-end for the SPI packet core: TX/RX word FIFOs, a packet
// sequencer driving go_transfer / data_pack_ready, sticky error flags and irq.
module spi_avalon_csr
   import spi_avalon_pkg::*;
#(
   parameter int FIFO_DEPTH     = 8,
   parameter int GO_HOLD        = 2,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic        clk_shift,
   input  logic        reset_n,
   input  logic [1:0]  avs_address,
   input  logic        avs_write,
   input  logic [31:0] avs_writedata,
   input  logic        avs_read,
   output logic [31:0] avs_readdata,
   output logic        go_transfer,
   output logic [31:0] data_write_from_avalon,
   input  logic [31:0] data_read_to_avalon,
   input  logic        data_pack_ready,
   output logic        irq
);

   localparam int LW = $clog2(FIFO_DEPTH) + 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int HW = $clog2(GO_HOLD + 1);

   state_t        r_state;
   logic [HW-1:0] r_go_cnt;
   logic [TW-1:0] r_timer;
   logic          r_go;
   logic [31:0]   r_dw;
   logic [31:0]   r_readdata;
   logic          r_enable;
   logic          r_irq_en;
   logic          r_tx_ovf;
   logic          r_rx_ovf;
   logic          r_timeout;
   logic          r_irq;

   logic          w_wr_tx, w_rd_rx, w_clr;
   logic          w_tx_pop, w_rx_push;
   logic          w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
   logic [LW-1:0] w_tx_level, w_rx_level;
   logic [31:0]   w_tx_head, w_rx_head;
   logic          w_tx_ovf_evt, w_rx_ovf_evt, w_timeout_evt;
   logic [31:0]   w_status;
   logic [31:0]   w_rdata;

   assign w_wr_tx   = avs_write & (avs_address == REG_TXDATA);
   assign w_rd_rx   = avs_read  & (avs_address == REG_RXDATA);
   assign w_clr     = avs_write & (avs_address == REG_CONTROL) & avs_writedata[CTL_CLR];
   assign w_tx_pop  = (r_state == LOAD);
   assign w_rx_push = (r_state == CAPTURE);

   // A full FIFO that is also being popped this cycle still takes the word.
   assign w_tx_ovf_evt  = w_wr_tx & w_tx_full & ~w_tx_pop;
   assign w_rx_ovf_evt  = w_rx_push & w_rx_full & ~w_rd_rx;
   assign w_timeout_evt = (r_state == WAIT_DONE) & ~data_pack_ready &
                          (r_timer == TW'(TIMEOUT_CYCLES - 1));

   spi_word_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk_shift (clk_shift),
      .reset_n   (reset_n),
      .i_push    (w_wr_tx),
      .i_pop     (w_tx_pop),
      .i_wdata   (avs_writedata),
      .o_rdata   (w_tx_head),
      .o_full    (w_tx_full),
      .o_empty   (w_tx_empty),
      .o_level   (w_tx_level)
   );

   spi_word_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk_shift (clk_shift),
      .reset_n   (reset_n),
      .i_push    (w_rx_push),
      .i_pop     (w_rd_rx),
      .i_wdata   (data_read_to_avalon),
      .o_rdata   (w_rx_head),
      .o_full    (w_rx_full),
      .o_empty   (w_rx_empty),
      .o_level   (w_rx_level)
   );

   always_comb begin
      w_status = '0;
      w_status[ST_BUSY]          = (r_state != IDLE);
      w_status[ST_TX_FULL]       = w_tx_full;
      w_status[ST_TX_EMPTY]      = w_tx_empty;
      w_status[ST_RX_FULL]       = w_rx_full;
      w_status[ST_RX_EMPTY]      = w_rx_empty;
      w_status[ST_TX_OVF]        = r_tx_ovf;
      w_status[ST_RX_OVF]        = r_rx_ovf;
      w_status[ST_TIMEOUT]       = r_timeout;
      w_status[ST_TX_LVL +: 8]   = 8'(w_tx_level);
      w_status[ST_RX_LVL +: 8]   = 8'(w_rx_level);
   end

   always_comb begin
      w_rdata = '0;
      case (avs_address)
         REG_RXDATA:  w_rdata = w_rx_empty ? 32'h0 : w_rx_head;
         REG_STATUS:  w_rdata = w_status;
         REG_CONTROL: w_rdata = {30'b0, r_irq_en, r_enable};
         default:     w_rdata = '0;
      endcase
   end

   always_ff @(posedge clk_shift or negedge reset_n) begin
      if (!reset_n) begin
         r_readdata <= '0;
         r_enable   <= 1'b0;
         r_irq_en   <= 1'b0;
         r_tx_ovf   <= 1'b0;
         r_rx_ovf   <= 1'b0;
         r_timeout  <= 1'b0;
         r_irq      <= 1'b0;
      end else begin
         if (avs_read) r_readdata <= w_rdata;
         if (avs_write && avs_address == REG_CONTROL) begin
            r_enable <= avs_writedata[CTL_ENABLE];
            r_irq_en <= avs_writedata[CTL_IRQ_EN];
         end
         // A new event in the clearing cycle wins over the clear.
         r_tx_ovf  <= (r_tx_ovf  & ~w_clr) | w_tx_ovf_evt;
         r_rx_ovf  <= (r_rx_ovf  & ~w_clr) | w_rx_ovf_evt;
         r_timeout <= (r_timeout & ~w_clr) | w_timeout_evt;
         r_irq     <= r_irq_en & (~w_rx_empty | r_tx_ovf | r_rx_ovf | r_timeout);
      end
   end

   always_ff @(posedge clk_shift or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= IDLE;
         r_go     <= 1'b0;
         r_go_cnt <= '0;
         r_timer  <= '0;
         r_dw     <= '0;
      end else begin
         case (r_state)
            // Looking at the incoming write gives LOAD the cycle after TXDATA.
            IDLE: if (r_enable && (!w_tx_empty || w_wr_tx)) r_state <= LOAD;
            LOAD: begin
               r_dw     <= w_tx_head;
               r_go     <= 1'b1;
               r_go_cnt <= '0;
               r_state  <= GO;
            end
            GO: begin
               if (r_go_cnt == HW'(GO_HOLD - 1)) begin
                  r_go    <= 1'b0;
                  r_timer <= '0;
                  r_state <= WAIT_DONE;
               end else begin
                  r_go_cnt <= r_go_cnt + HW'(1);
               end
            end
            WAIT_DONE: begin
               if (data_pack_ready)    r_state <= CAPTURE;
               else if (w_timeout_evt) r_state <= IDLE;
               else                    r_timer <= r_timer + TW'(1);
            end
            CAPTURE:      r_state <= WAIT_RELEASE;
            WAIT_RELEASE: if (!data_pack_ready) r_state <= IDLE;
            default:      r_state <= IDLE;
         endcase
      end
   end

   assign avs_readdata           = r_readdata;
   assign go_transfer            = r_go;
   assign data_write_from_avalon = r_dw;
   assign irq                    = r_irq;

endmodule

// File: tb/tb_spi_avalon_csr.sv
// Directed bench for spi_avalon_csr with a small SPI core responder model.
module tb_spi_avalon_csr;

   logic        clk_shift = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  avs_address = '0;
   logic        avs_write = 1'b0;
   logic [31:0] avs_writedata = '0;
   logic        avs_read = 1'b0;
   logic [31:0] avs_readdata;
   logic        go_transfer;
   logic [31:0] data_write_from_avalon;
   logic [31:0] data_read_to_avalon = '0;
   logic        data_pack_ready = 1'b0;
   logic        irq;

   int checks = 0;
   int failures = 0;
   bit core_on = 1'b0;
   logic [31:0] core_xor;

   spi_avalon_csr dut (
      .clk_shift              (clk_shift),
      .reset_n                (reset_n),
      .avs_address            (avs_address),
      .avs_write              (avs_write),
      .avs_writedata          (avs_writedata),
      .avs_read               (avs_read),
      .avs_readdata           (avs_readdata),
      .go_transfer            (go_transfer),
      .data_write_from_avalon (data_write_from_avalon),
      .data_read_to_avalon    (data_read_to_avalon),
      .data_pack_ready        (data_pack_ready),
      .irq                    (irq)
   );

   always #5 clk_shift = ~clk_shift;

   // Core model: answers each go_transfer with tx^core_xor, ready held 2 cycles.
   initial begin
      forever begin
         @(posedge clk_shift);
         if (go_transfer && core_on) begin
            repeat (3) @(posedge clk_shift);
            #1;
            data_read_to_avalon = data_write_from_avalon ^ core_xor;
            data_pack_ready = 1'b1;
            repeat (2) @(posedge clk_shift);
            #1;
            data_pack_ready = 1'b0;
         end
      end
   end

   task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk_shift);
      avs_address = a; avs_writedata = d; avs_write = 1'b1;
      @(negedge clk_shift);
      avs_write = 1'b0;
   endtask

   task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk_shift);
      avs_address = a; avs_read = 1'b1;
      @(negedge clk_shift);
      avs_read = 1'b0;
      d = avs_readdata;
   endtask

   // Polls STATUS until idle with an empty TX FIFO; done=0 if the bound expires.
   task automatic wait_idle(output bit done, output logic [31:0] s);
      done = 1'b0;
      s = '0;
      for (int i = 0; i < 400; i++) begin
         bus_rd(2'd2, s);
         if (!s[0] && s[2]) begin
            done = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      logic [31:0] d;
      repeat (3) @(negedge clk_shift);
      checks++; if (go_transfer !== 1'b0) begin failures++; $display("FAIL reset_go got=%b exp=0", go_transfer); end
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
      checks++; if (data_write_from_avalon !== 32'h0) begin failures++; $display("FAIL reset_dw got=%h exp=0", data_write_from_avalon); end
      reset_n = 1'b1;
      bus_rd(2'd2, d);
      checks++; if (d !== 32'h0000_0014) begin failures++; $display("FAIL reset_status got=%h exp=00000014", d); end
      bus_rd(2'd3, d);
      checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_control got=%h exp=0", d); end
      bus_rd(2'd1, d);
      checks++; if (d !== 32'h0) begin failures++; $display("FAIL empty_rxdata got=%h exp=0", d); end
   endtask

   task automatic test_single_packet();
      logic [31:0] d;
      bit seen;
      core_on = 1'b1;
      bus_wr(2'd3, 32'h3);
      bus_wr(2'd0, 32'hA5A5_1234);
      checks++; if (go_transfer !== 1'b0) begin failures++; $display("FAIL go_in_load got=%b exp=0", go_transfer); end
      @(negedge clk_shift);
      checks++; if (go_transfer !== 1'b1) begin failures++; $display("FAIL go_first got=%b exp=1", go_transfer); end
      checks++; if (data_write_from_avalon !== 32'hA5A5_1234) begin failures++; $display("FAIL tx_word got=%h exp=a5a51234", data_write_from_avalon); end
      @(negedge clk_shift);
      checks++; if (go_transfer !== 1'b1) begin failures++; $display("FAIL go_second got=%b exp=1", go_transfer); end
      @(negedge clk_shift);
      checks++; if (go_transfer !== 1'b0) begin failures++; $display("FAIL go_drop got=%b exp=0", go_transfer); end
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk_shift);
         if (irq) begin seen = 1'b1; break; end
      end
      checks++; if (!seen) begin failures++; $display("FAIL irq_rise got=0 exp=1 (bound expired)"); end
      bus_rd(2'd1, d);
      checks++; if (d !== 32'h5A5A_ABCD) begin failures++; $display("FAIL rx_word got=%h exp=5a5aabcd", d); end
      @(negedge clk_shift);
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_fall got=%b exp=0", irq); end
      bus_rd(2'd2, d);
      checks++; if (d !== 32'h0000_0014) begin failures++; $display("FAIL status_after_pkt got=%h exp=00000014", d); end
   endtask

   task automatic test_tx_overflow();
      logic [31:0] d;
      bit done;
      bus_wr(2'd3, 32'h2);
      for (int i = 0; i < 9; i++) bus_wr(2'd0, 32'h1000_0000 + 32'(i));
      bus_rd(2'd2, d);
      checks++; if (d !== 32'h0000_0832) begin failures++; $display("FAIL txovf_status got=%h exp=00000832", d); end
      checks++; if (irq !== 1'b1) begin failures++; $display("FAIL txovf_irq got=%b exp=1", irq); end
      bus_wr(2'd3, 32'h7);
      bus_rd(2'd2, d);
      checks++; if (d[7:5] !== 3'b000) begin failures++; $display("FAIL flag_clear got=%b exp=000", d[7:5]); end
      bus_rd(2'd3, d);
      checks++; if (d !== 32'h3) begin failures++; $display("FAIL control_rb got=%h exp=3", d); end
      wait_idle(done, d);
      checks++; if (!done) begin failures++; $display("FAIL drain8 got=busy exp=idle (bound expired)"); end
      checks++; if (d !== 32'h0008_000C) begin failures++; $display("FAIL rx8_status got=%h exp=0008000c", d); end
   endtask

   task automatic test_rx_overflow();
      logic [31:0] d;
      bit done;
      bus_wr(2'd0, 32'hDEAD_BEEF);
      wait_idle(done, d);
      checks++; if (!done) begin failures++; $display("FAIL drain9 got=busy exp=idle (bound expired)"); end
      checks++; if (d !== 32'h0008_004C) begin failures++; $display("FAIL rxovf_status got=%h exp=0008004c", d); end
      for (int i = 0; i < 8; i++) begin
         bus_rd(2'd1, d);
         checks++;
         if (d !== ((32'h1000_0000 + 32'(i)) ^ core_xor)) begin
            failures++;
            $display("FAIL rx_order[%0d] got=%h exp=%h", i, d, (32'h1000_0000 + 32'(i)) ^ core_xor);
         end
      end
      bus_rd(2'd2, d);
      checks++; if (d !== 32'h0000_0054) begin failures++; $display("FAIL rx_drained_status got=%h exp=00000054", d); end
      bus_wr(2'd3, 32'h7);
   endtask

   task automatic test_timeout_and_reset();
      logic [31:0] d;
      int n;
      core_on = 1'b0;
      bus_wr(2'd0, 32'h1111_0001);
      bus_wr(2'd0, 32'h2222_0002);
      for (int i = 0; i < 20 && !go_transfer; i++) @(negedge clk_shift);
      checks++; if (data_write_from_avalon !== 32'h1111_0001) begin failures++; $display("FAIL to_w1 got=%h exp=11110001", data_write_from_avalon); end
      for (int i = 0; i < 10 && go_transfer; i++) @(negedge clk_shift);
      n = 1;
      while (!go_transfer && n < 4300) begin
         @(negedge clk_shift);
         if (!go_transfer) n++;
      end
      checks++; if (n != 4098) begin failures++; $display("FAIL timeout_gap got=%0d exp=4098", n); end
      checks++; if (data_write_from_avalon !== 32'h2222_0002) begin failures++; $display("FAIL to_w2 got=%h exp=22220002", data_write_from_avalon); end
      checks++; if (irq !== 1'b1) begin failures++; $display("FAIL timeout_irq got=%b exp=1", irq); end
      #1 reset_n = 1'b0;
      #1;
      checks++; if (go_transfer !== 1'b0) begin failures++; $display("FAIL async_go got=%b exp=0", go_transfer); end
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL async_irq got=%b exp=0", irq); end
      @(negedge clk_shift);
      reset_n = 1'b1;
      bus_rd(2'd2, d);
      checks++; if (d !== 32'h0000_0014) begin failures++; $display("FAIL post_reset_status got=%h exp=00000014", d); end
      bus_rd(2'd3, d);
      checks++; if (d !== 32'h0) begin failures++; $display("FAIL post_reset_control got=%h exp=0", d); end
   endtask

   initial begin
      core_xor = 32'hA5A5_1234 ^ 32'h5A5A_ABCD;
      test_reset();
      test_single_packet();
      test_tx_overflow();
      test_rx_overflow();
      test_timeout_and_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
